ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Small instruction queue between the prefetch/instruction cache and the instruction decoder. It accepts (instruction, PC, illegal) words from the fetch stage's valid/stall handshake and replays them in order to the decoder. This decouples decoder stalls from cache reads so the cache can keep fetching into spare slots. It flushes on a new PC and stops accepting words after a bus-error (illegal) word until the next flush.

## Interface

Parameters:
- AW, 24: address (PC) width in words.
- LGDEPTH, 2: log2 of queue depth; DEPTH = 1<<LGDEPTH, LGDEPTH >= 1.

Ports:
- i_clk, input, 1: clock; everything is on the rising edge.
- i_rst_n, input, 1: reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- i_new_pc, input, 1: branch/new PC; flushes the queue.
- i_v, input, 1: upstream word valid.
- i_i, input, 32: upstream instruction.
- i_pc, input, AW: upstream PC.
- i_illegal, input, 1: upstream bus-error flag for this word.
- o_stall_n, output, 1: ready to upstream; drives the fetch stage's stall_n.
- o_v, output, 1: word valid to decoder.
- o_i, output, 32: head instruction.
- o_pc, output, AW: head PC.
- o_illegal, output, 1: head word's illegal flag.
- i_stall_n, input, 1: decoder ready.
- o_fill, output, LGDEPTH+1: number of held words, 0..DEPTH.

## Operation

- Storage: DEPTH entries of {illegal, pc, instruction}, organised as a circular buffer with LGDEPTH-bit read/write pointers. Pointers wrap modulo DEPTH.
- Head: o_i/o_pc/o_illegal are a registered head copy. The head register is loaded when the queue goes non-empty or when a pop leaves it non-empty.
- push = i_v && o_stall_n && !i_new_pc.
- pop = o_v && i_stall_n.
- Fill update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. This is legal at any fill below DEPTH, including fill=1, where the pushed word becomes the next head.
- o_stall_n = (o_fill != DEPTH) && !halt. It is derived from registered state only; there is no combinational path from i_stall_n.
- halt flag:
  - Set on a push with i_illegal=1.
  - Cleared by i_new_pc.
  - While set, no further pushes are accepted. Words already queued, including the illegal word, still drain in order.
- o_v = (o_fill != 0) && !i_new_pc. The i_new_pc term is combinational gating, so the decoder never consumes a stale word in the flush cycle.
- Flush (i_new_pc=1 at an edge):
  - Pointers, o_fill and halt go to 0.
  - Any same-cycle push is discarded.
  - The head register keeps its value but o_v stays 0.
- Flush has priority over push and pop. Reset has priority over everything.

## Timing

- Reset values: o_v=0, o_fill=0, o_stall_n=1 (after i_rst_n rises), o_i=0, o_pc=0, o_illegal=0, halt=0, pointers=0.
- With i_rst_n low, o_stall_n=0 and o_v=0.
- Latency: a push at edge N into an empty queue gives o_v=1 with that word during cycle N+1. There is no fall-through in the same cycle.
- Throughput: one word per cycle sustained when i_v=1 and i_stall_n=1. In steady state o_fill=1.
- Full: o_stall_n falls in the cycle after the DEPTH-th push. It rises in the cycle after the first pop.
- Empty: a pop with no push drops o_v in the next cycle.
- Held data: o_i/o_pc/o_illegal hold their last values while o_v=0. They are stable while o_v=1 and i_stall_n=0.
- Wrap: pointers wrap from DEPTH-1 to 0 with no bubble.
- Reset mid-operation: asserting i_rst_n low forces all outputs to their reset values immediately, without waiting for an edge.

## Test plan

1. Streaming: reset, then push PCs 0x100, 0x101, 0x102 back-to-back with i_stall_n=1. The same words appear on o_pc in cycles 1–3 after each push, o_fill never exceeds 1, and o_stall_n stays 1.
2. Fill and wrap (LGDEPTH=2): hold i_stall_n=0 and offer 0x200..0x204.
   - Four words are accepted, o_fill=4, o_stall_n=0, and 0x204 is held off.
   - Release i_stall_n: the bench sees 0x200..0x204 in order, and 0x204 is accepted one cycle after the first pop.
   - Repeat for 3 laps to exercise pointer wrap.
3. Flush: with o_fill=3, assert i_new_pc for one cycle while i_v=1 (PC 0x300). o_v=0 in that cycle, o_fill=0 next cycle, 0x300 is never delivered, and o_stall_n=1.
4. Illegal:
   - Push 0x400 normally, then push 0x401 with i_illegal=1. o_stall_n=0 thereafter and 0x402 is not accepted.
   - The decoder sees 0x400 (o_illegal=0), then 0x401 (o_illegal=1).
   - A subsequent i_new_pc restores o_stall_n=1.
5. Simultaneous push and pop: at o_fill=2, push 0x500 while popping. o_fill stays 2 and order is preserved. Repeat at o_fill=1: the head advances to the next word with no bubble.
6. Asynchronous reset: with o_fill=3 and o_v=1, pull i_rst_n low mid-cycle. o_v=0 and o_fill=0 before the next edge. After release, the first push behaves as in scenario 1.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: circular buffer between the instruction cache and the decoder.
// Flushes on a new PC and stops accepting words after an illegal word until the next flush.
module ifetch_queue #(
  parameter int AW      = 24,
  parameter int LGDEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_new_pc,
  input  logic               i_v,
  input  logic [31:0]        i_i,
  input  logic [AW-1:0]      i_pc,
  input  logic               i_illegal,
  output logic               o_stall_n,
  output logic               o_v,
  output logic [31:0]        o_i,
  output logic [AW-1:0]      o_pc,
  output logic               o_illegal,
  input  logic               i_stall_n,
  output logic [LGDEPTH:0]   o_fill
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam int EW    = 33 + AW;

  logic [EW-1:0]      r_mem [DEPTH];
  logic [LGDEPTH-1:0] r_rd_ptr, r_wr_ptr;
  logic [LGDEPTH:0]   r_fill;
  logic               r_halt;
  logic [31:0]        r_i;
  logic [AW-1:0]      r_pc;
  logic               r_illegal;

  logic               w_full, w_empty, w_push, w_pop, w_load;
  logic [EW-1:0]      w_in_word, w_head_nxt;
  logic [LGDEPTH-1:0] w_rd_nxt;

  assign w_full    = (r_fill == (LGDEPTH+1)'(DEPTH));
  assign w_empty   = (r_fill == '0);
  assign o_stall_n = i_rst_n && !w_full && !r_halt;
  assign o_v       = !w_empty && !i_new_pc;
  assign w_push    = i_v && o_stall_n && !i_new_pc;
  assign w_pop     = o_v && i_stall_n;
  assign w_in_word = {i_illegal, i_pc, i_i};
  assign w_rd_nxt  = r_rd_ptr + LGDEPTH'(1);

  // Next head comes from the incoming word when the queue would otherwise be empty
  // after this edge (push into empty, or push+pop at fill=1); otherwise from storage.
  always_comb begin
    w_load     = 1'b0;
    w_head_nxt = w_in_word;
    if (w_push && (w_empty || (w_pop && r_fill == (LGDEPTH+1)'(1)))) begin
      w_load = 1'b1;
    end else if (w_pop && r_fill > (LGDEPTH+1)'(1)) begin
      w_load     = 1'b1;
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_halt   <= 1'b0;
    end else if (i_new_pc) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_halt   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LGDEPTH'(1);
        if (i_illegal) r_halt <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= w_rd_nxt;
      if (w_push && !w_pop)      r_fill <= r_fill + (LGDEPTH+1)'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - (LGDEPTH+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i       <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      {r_illegal, r_pc, r_i} <= w_head_nxt;
    end
  end

  assign o_i       = r_i;
  assign o_pc      = r_pc;
  assign o_illegal = r_illegal;
  assign o_fill    = r_fill;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed table-driven bench for ifetch_queue (AW=24, LGDEPTH=2).
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_pc, v, illegal, stall_n;
  logic [31:0] ins;
  logic [23:0] pc;
  logic        o_stall_n, o_v, o_illegal;
  logic [31:0] o_i;
  logic [23:0] o_pc;
  logic [2:0]  o_fill;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ifetch_queue #(.AW(24), .LGDEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_new_pc(new_pc), .i_v(v), .i_i(ins),
    .i_pc(pc), .i_illegal(illegal), .o_stall_n(o_stall_n), .o_v(o_v),
    .o_i(o_i), .o_pc(o_pc), .o_illegal(o_illegal), .i_stall_n(stall_n),
    .o_fill(o_fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        np, v;
    logic [23:0] pc;
    logic        ill, sn;
    logic        ev;
    logic [23:0] epc;
    logic        eill;
    logic [2:0]  efill;
    logic        estn;
    logic        chkd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] ins_of(input logic [23:0] p);
    return {8'h5A, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic np, input logic vv, input logic [23:0] p,
                              input logic il, input logic sn, input logic ev,
                              input logic [23:0] epc, input logic eill,
                              input logic [2:0] efill, input logic estn, input logic chkd);
    vec_t t;
    t.np = np; t.v = vv; t.pc = p; t.ill = il; t.sn = sn;
    t.ev = ev; t.epc = epc; t.eill = eill; t.efill = efill; t.estn = estn; t.chkd = chkd;
    tbl.push_back(t);
  endfunction

  // Called at a negedge: drive, settle, compare, advance to the next negedge.
  task automatic apply(input int unsigned lo, input int unsigned hi);
    for (int unsigned k = lo; k <= hi; k++) begin
      new_pc = tbl[k].np; v = tbl[k].v; pc = tbl[k].pc; ins = ins_of(tbl[k].pc);
      illegal = tbl[k].ill; stall_n = tbl[k].sn;
      #1;
      check($sformatf("v%0d_o_v", k), 64'(o_v), 64'(tbl[k].ev));
      check($sformatf("v%0d_fill", k), 64'(o_fill), 64'(tbl[k].efill));
      check($sformatf("v%0d_stall_n", k), 64'(o_stall_n), 64'(tbl[k].estn));
      if (tbl[k].chkd) begin
        check($sformatf("v%0d_o_pc", k), 64'(o_pc), 64'(tbl[k].epc));
        check($sformatf("v%0d_o_i", k), 64'(o_i), 64'(ins_of(tbl[k].epc)));
        check($sformatf("v%0d_o_ill", k), 64'(o_illegal), 64'(tbl[k].eill));
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [23:0] b;
    // Streaming: vectors 0..4
    add(0,1,24'h100,0,1, 0,24'h0,0,0,1,0);
    add(0,1,24'h101,0,1, 1,24'h100,0,1,1,1);
    add(0,1,24'h102,0,1, 1,24'h101,0,1,1,1);
    add(0,0,24'h0,0,1,   1,24'h102,0,1,1,1);
    add(0,0,24'h0,0,1,   0,24'h102,0,0,1,1);
    // Fill, full and wrap: three laps, 10 vectors each
    for (int lap = 0; lap < 3; lap++) begin
      b = 24'h200 + 24'(lap * 16);
      add(0,1,b+0,0,0, 0,24'h0,0,0,1,0);
      add(0,1,b+1,0,0, 1,b+0,0,1,1,1);
      add(0,1,b+2,0,0, 1,b+0,0,2,1,1);
      add(0,1,b+3,0,0, 1,b+0,0,3,1,1);
      add(0,1,b+4,0,0, 1,b+0,0,4,0,1);
      add(0,1,b+4,0,1, 1,b+0,0,4,0,1);
      add(0,1,b+4,0,1, 1,b+1,0,3,1,1);
      add(0,0,24'h0,0,1, 1,b+2,0,3,1,1);
      add(0,0,24'h0,0,1, 1,b+3,0,2,1,1);
      add(0,0,24'h0,0,1, 1,b+4,0,1,1,1);
    end
    // Flush at fill=3 with a same-cycle offered word
    add(0,1,24'h2F0,0,0, 0,24'h0,0,0,1,0);
    add(0,1,24'h2F1,0,0, 1,24'h2F0,0,1,1,1);
    add(0,1,24'h2F2,0,0, 1,24'h2F0,0,2,1,1);
    add(1,1,24'h300,0,1, 0,24'h2F0,0,3,1,1);
    add(0,0,24'h0,0,1,   0,24'h2F0,0,0,1,1);
    add(0,0,24'h0,0,1,   0,24'h2F0,0,0,1,1);
    // Illegal word halts acceptance until a flush
    add(0,1,24'h400,0,0, 0,24'h0,0,0,1,0);
    add(0,1,24'h401,1,0, 1,24'h400,0,1,1,1);
    add(0,1,24'h402,0,0, 1,24'h400,0,2,0,1);
    add(0,1,24'h402,0,1, 1,24'h400,0,2,0,1);
    add(0,1,24'h402,0,1, 1,24'h401,1,1,0,1);
    add(0,1,24'h402,0,1, 0,24'h401,1,0,0,1);
    add(1,0,24'h0,0,1,   0,24'h401,1,0,0,1);
    add(0,0,24'h0,0,1,   0,24'h401,1,0,1,1);
    // Simultaneous push and pop at fill=2 and fill=1
    add(0,1,24'h4F0,0,0, 0,24'h0,0,0,1,0);
    add(0,1,24'h4F1,0,0, 1,24'h4F0,0,1,1,1);
    add(0,1,24'h500,0,1, 1,24'h4F0,0,2,1,1);
    add(0,0,24'h0,0,1,   1,24'h4F1,0,2,1,1);
    add(0,1,24'h501,0,1, 1,24'h500,0,1,1,1);
    add(0,0,24'h0,0,1,   1,24'h501,0,1,1,1);
    add(0,0,24'h0,0,1,   0,24'h501,0,0,1,1);

    rst_n = 1'b0; new_pc = 0; v = 0; pc = '0; ins = '0; illegal = 0; stall_n = 1;
    @(posedge clk); @(negedge clk);
    check("rst_o_v", 64'(o_v), 64'(0));
    check("rst_stall_n_low", 64'(o_stall_n), 64'(0));
    check("rst_fill", 64'(o_fill), 64'(0));
    check("rst_o_pc", 64'(o_pc), 64'(0));
    check("rst_o_i", 64'(o_i), 64'(0));
    check("rst_o_ill", 64'(o_illegal), 64'(0));
    rst_n = 1'b1;
    #1 check("rst_rel_stall_n", 64'(o_stall_n), 64'(1));
    @(negedge clk);

    apply(0, tbl.size() - 1);

    // Asynchronous reset with three words queued
    stall_n = 0; new_pc = 0; illegal = 0;
    for (int j = 0; j < 3; j++) begin
      v = 1; pc = 24'h600 + 24'(j); ins = ins_of(pc);
      @(posedge clk); @(negedge clk);
    end
    v = 0;
    #1;
    check("pre_arst_fill", 64'(o_fill), 64'(3));
    check("pre_arst_o_v", 64'(o_v), 64'(1));
    check("pre_arst_o_pc", 64'(o_pc), 64'(24'h600));
    #1 rst_n = 1'b0;
    #1;
    check("arst_o_v", 64'(o_v), 64'(0));
    check("arst_fill", 64'(o_fill), 64'(0));
    check("arst_stall_n", 64'(o_stall_n), 64'(0));
    check("arst_o_pc", 64'(o_pc), 64'(0));
    check("arst_o_i", 64'(o_i), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
